// File: rtl/uart_line_fifo.sv
// Byte FIFO behind uart_rx that counts buffered complete lines and reports a per-line byte sum.
// Latency: an accepted byte is on o_data/o_valid after the same edge (fall-through); the line sum follows the eol edge.
// Backpressure: none to the receiver; a byte arriving when full without a pop is dropped and latches o_overflow.
// UART_LINE_FIFO_STRIP_CR_EN: when defined, 8'h0D bytes are discarded at the input.
module uart_line_fifo #(
  parameter int         depth    = 16,
  parameter logic [7:0] eol_char = 8'h0A
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  output logic [$clog2(depth):0]   o_count,
  output logic [$clog2(depth):0]   o_lines,
  output logic [31:0]              o_line_sum,
  output logic                     o_line_done,
  output logic                     o_overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [aw-1:0] ptr_one  = 1;
  localparam logic [cw-1:0] cnt_one  = 1;
  localparam logic [cw-1:0] cnt_full = cw'(depth);

  logic [7:0]    mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [cw-1:0] count;
  logic [cw-1:0] lines;
  logic [31:0]   acc;
  logic [31:0]   line_sum;
  logic          line_done;
  logic          overflow;

  logic [7:0]    head;
  logic          is_cr;
  logic          in_vld;
  logic          pop_ok;
  logic          push_ok;
  logic          push_eol;
  logic          pop_eol;
  logic [31:0]   acc_sum;

`ifdef UART_LINE_FIFO_STRIP_CR_EN
  assign is_cr = (i_data == 8'h0D);
`else
  assign is_cr = 1'b0;
`endif

  assign head     = mem[rd_ptr];
  assign in_vld   = i_valid && !is_cr;
  assign pop_ok   = i_pop && (count != '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte when it is being drained.
  assign push_ok  = in_vld && ((count != cnt_full) || pop_ok);
  assign push_eol = push_ok && (i_data == eol_char);
  assign pop_eol  = pop_ok && (head == eol_char);
  assign acc_sum  = acc + {24'h0, i_data};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lines     <= '0;
      acc       <= '0;
      line_sum  <= '0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_one;
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_one;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase

      case ({push_eol, pop_eol})
        2'b10:   lines <= lines + cnt_one;
        2'b01:   lines <= lines - cnt_one;
        default: lines <= lines;
      endcase

      line_done <= push_eol;
      if (push_eol) begin
        line_sum <= acc_sum;
        acc      <= '0;
      end else if (push_ok) begin
        acc <= acc_sum;
      end

      if (in_vld && !push_ok) overflow <= 1'b1;
    end
  end

  assign o_valid     = (count != '0);
  assign o_data      = o_valid ? head : 8'h00;
  assign o_count     = count;
  assign o_lines     = lines;
  assign o_line_sum  = line_sum;
  assign o_line_done = line_done;
  assign o_overflow  = overflow;

endmodule
